btn_irq: RTL and testbench
==========================

# btn_irq

Button input conditioner and interrupt source for the CPU. It synchronises and debounces the seven board buttons and latches their edges into a pending register with a per-bit enable. It drives the CPU `irq[0]` line and is a bus slave on bank `8'h05`. It takes over the raw `btn[6]` → `irq[0]` connection and exposes the debounced button levels to firmware.

## Interface
Parameters:
- `DEBOUNCE`, 250000: number of consecutive stable cycles before a level change is accepted (10 ms at 25 MHz); minimum 2.
- `CW`, 18: debounce counter width; must satisfy 2^CW > DEBOUNCE.
- `RST_LEVEL`, 7'h01: reset value of the synchroniser and debounced levels (btn[0] idles high).

Ports:
- `clk`  in  1  system clock (25 MHz).
- `rst_i`  in  1  reset; one clock; reset is asynchronous and active-low.
- `btn`  in  7  raw asynchronous button inputs.
- `adr_i`  in  4  byte address within bank; only `adr_i[3:2]` is decoded.
- `dat_i`  in  32  write data.
- `sel_i`  in  4  byte-lane enables for writes.
- `we_i`  in  1  1 = write, 0 = read.
- `stb_i`  in  1  bank select AND CPU strobe; held high until `ack_o`.
- `ack_o`  out  1  single-cycle transfer acknowledge.
- `dat_o`  out  32  read data; valid while `ack_o` = 1.
- `irq_o`  out  1  level interrupt to CPU `irq[0]`.

## Operation
- Synchroniser: two flops per button, reset to `RST_LEVEL`.
- Debounce, per bit i, with a counter `cnt[i]` of width CW:
  - sync == level: `cnt` ← 0.
  - sync != level and `cnt` == DEBOUNCE-1: `level` ← sync, `cnt` ← 0, and a one-cycle event fires (rise if the new level is 1, fall if 0).
  - otherwise: `cnt` ← `cnt` + 1.
  - Any glitch shorter than DEBOUNCE cycles is discarded.
- Registers. All bits [31:7] not listed read 0; writes to them are ignored; writes honour `sel_i` lanes.
  - 0x0 LEVEL (RO): `[6:0]` debounced level.
  - 0x4 PENDING (W1C): `[6:0]`; bit i set by an enabled event on i; writing 1 clears it.
  - 0x8 ENABLE (RW): `[6:0]` interrupt enable.
  - 0xC EDGE (RW): `[6:0]` rise enable, `[14:8]` fall enable.
- A pending bit is set when an event fires and the corresponding EDGE bit is 1. Setting is independent of ENABLE, so firmware can poll.
- `irq_o` = |(PENDING & ENABLE), registered.
- Set and W1C clear of the same pending bit in the same cycle: set wins, and the bit stays 1.
- Writes to LEVEL are ignored and ack normally.

## Timing
- Reset (`rst_i` = 0, asynchronous): sync and level = `RST_LEVEL`; `cnt` = 0; PENDING, ENABLE and EDGE = 0; `ack_o` = 0; `dat_o` = 0; `irq_o` = 0.
- Bus handshake:
  - `ack_o` ← `stb_i` & ~`ack_o`, so ack rises one cycle after `stb_i` and lasts exactly one cycle.
  - Back-to-back strobes get at most one ack every two cycles.
  - A write commits on the same edge that raises `ack_o`.
  - Read data is registered on that edge and held until the next ack. A read in the same cycle as a write returns the pre-write value.
- Pin to event latency: 2 sync cycles + DEBOUNCE cycles after the pin settles.
- Event to pending: 1 cycle. Pending/enable change to `irq_o`: 1 cycle.
- W1C clear to `irq_o` low: 1 cycle after the ack edge.
- Reset asserted mid-debounce: the count is lost and no event is produced. Reset mid-transfer: no ack is issued for that strobe.
- Raw input equal to `RST_LEVEL` at reset release: no event ever fires for it.

## Test plan
- Reset value readback, with DEBOUNCE=4 for the whole bench. Release reset with `btn`=7'h01, then read 0x0/0x4/0x8/0xC. Required: each ack arrives 1 cycle after stb and lasts 1 cycle; read values are 0x01, 0, 0, 0; `irq_o`=0.
- Rising-edge interrupt:
  - Write EDGE=0x40 and ENABLE=0x40, then hold btn[6]=1.
  - Required: PENDING=0x40 and `irq_o`=1 exactly 2+4+1+1 cycles after the pin change.
  - Write 0x40 to 0x4. Required: `irq_o`=0 one cycle after the ack.
- Glitch rejection: pulse btn[3] high for 3 cycles with EDGE=0x7F7F. Required: LEVEL unchanged and PENDING=0. Then hold it high for 8 cycles. Required: LEVEL bit3=1 and PENDING bit3=1.
- Fall edge with interrupt masked:
  - EDGE=0x0100 and ENABLE=0; drop btn[0] to 0.
  - Required: PENDING=0x01, LEVEL bit0=0, and `irq_o` stays 0. Then write ENABLE=0x01; required: `irq_o`=1 one cycle after the ack.
- Set/clear collision: arrange for a W1C of bit 2 to commit on the same cycle as a rise event on btn[2]. Required: PENDING bit2 stays 1.
- Byte lanes and asynchronous reset:
  - Write 0xFFFF to EDGE with `sel_i`=4'b0001. Required: EDGE reads 0x007F.
  - Assert `rst_i`=0 asynchronously mid-transfer. Required: all outputs go to 0 immediately with no ack, and all registers return to their reset values.

Source files
------------

// File: rtl/btn_irq.sv
// Button conditioner: two-flop synchroniser, per-bit debounce, edge-latched
// pending register with per-bit enable, and a single-cycle-ack bus slave.
module btn_irq #(
  parameter int          DEBOUNCE  = 250000,
  parameter int          CW        = 18,
  parameter logic [6:0]  RST_LEVEL = 7'h01
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [6:0]  btn,
  input  logic [3:0]  adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic        stb_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  output logic        irq_o
);

  localparam logic [CW-1:0] LP_CNT_MAX = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] LP_CNT_ONE = CW'(1);
  localparam logic [1:0]    LP_A_LEVEL = 2'd0;
  localparam logic [1:0]    LP_A_PEND  = 2'd1;
  localparam logic [1:0]    LP_A_EN    = 2'd2;
  localparam logic [1:0]    LP_A_EDGE  = 2'd3;

  logic [6:0]    r_sync1;
  logic [6:0]    r_sync2;
  logic [6:0]    r_level;
  logic [CW-1:0] r_cnt [7];
  logic [6:0]    r_rise;
  logic [6:0]    r_fall;
  logic [6:0]    r_pending;
  logic [6:0]    r_enable;
  logic [6:0]    r_edge_rise;
  logic [6:0]    r_edge_fall;
  logic          r_ack;
  logic [31:0]   r_dat;
  logic          r_irq;

  logic          w_acc;
  logic          w_wr;
  logic [6:0]    w_set;
  logic [6:0]    w_clr;
  logic [31:0]   w_rdata;
  logic          w_unused;

  function automatic logic [6:0] f_lane(input logic [6:0] old, input logic [6:0] wd,
                                        input logic en);
    return en ? wd : old;
  endfunction

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      r_sync1 <= RST_LEVEL;
      r_sync2 <= RST_LEVEL;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  // A level change is accepted only after DEBOUNCE consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      r_level <= RST_LEVEL;
      r_rise  <= '0;
      r_fall  <= '0;
      for (int i = 0; i < 7; i++) r_cnt[i] <= '0;
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < 7; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LP_CNT_MAX) begin
          r_level[i] <= r_sync2[i];
          r_cnt[i]   <= '0;
          r_rise[i]  <= r_sync2[i];
          r_fall[i]  <= ~r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + LP_CNT_ONE;
        end
      end
    end
  end

  assign w_acc = stb_i & ~r_ack;
  assign w_wr  = w_acc & we_i;
  assign w_set = (r_rise & r_edge_rise) | (r_fall & r_edge_fall);
  assign w_clr = (w_wr && adr_i[3:2] == LP_A_PEND && sel_i[0]) ? dat_i[6:0] : 7'h00;

  always_comb begin
    w_rdata = 32'h0;
    case (adr_i[3:2])
      LP_A_LEVEL: w_rdata[6:0] = r_level;
      LP_A_PEND:  w_rdata[6:0] = r_pending;
      LP_A_EN:    w_rdata[6:0] = r_enable;
      default:    w_rdata = {17'h0, r_edge_fall, 1'b0, r_edge_rise};
    endcase
  end

  // Set is ORed in after the clear, so a same-cycle event keeps the bit high.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      r_ack       <= 1'b0;
      r_dat       <= 32'h0;
      r_pending   <= '0;
      r_enable    <= '0;
      r_edge_rise <= '0;
      r_edge_fall <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_ack     <= w_acc;
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_irq     <= |(r_pending & r_enable);
      if (w_acc) r_dat <= w_rdata;
      if (w_wr && adr_i[3:2] == LP_A_EN)
        r_enable <= f_lane(r_enable, dat_i[6:0], sel_i[0]);
      if (w_wr && adr_i[3:2] == LP_A_EDGE) begin
        r_edge_rise <= f_lane(r_edge_rise, dat_i[6:0], sel_i[0]);
        r_edge_fall <= f_lane(r_edge_fall, dat_i[14:8], sel_i[1]);
      end
    end
  end

  assign ack_o    = r_ack;
  assign dat_o    = r_dat;
  assign irq_o    = r_irq;
  assign w_unused = ^{adr_i[1:0], dat_i[31:15], dat_i[7], sel_i[3:2]};

endmodule

// File: tb/tb_btn_irq.sv
// Directed bench for btn_irq with a short debounce window (DEBOUNCE=4).
module tb_btn_irq;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [6:0]  btn;
  logic [3:0]  adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic        we_i;
  logic        stb_i;
  logic        ack_o;
  logic [31:0] dat_o;
  logic        irq_o;

  int n_cmp = 0;
  int n_err = 0;

  btn_irq #(.DEBOUNCE(4), .CW(3), .RST_LEVEL(7'h01)) dut (
    .clk(clk), .rst_i(rst_i), .btn(btn), .adr_i(adr_i), .dat_i(dat_i),
    .sel_i(sel_i), .we_i(we_i), .stb_i(stb_i), .ack_o(ack_o), .dat_o(dat_o),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 two cycles later.
  task automatic bus_xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rdat);
    adr_i = a; dat_i = d; sel_i = s; we_i = w; stb_i = 1'b1;
    @(posedge clk); #1;
    chk("ack_rise", {31'h0, ack_o}, 32'h1);
    rdat  = dat_o;
    stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk); #1;
    chk("ack_single", {31'h0, ack_o}, 32'h0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    bus_xfer(1'b1, a, d, s, dummy);
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_xfer(1'b0, a, 32'h0, 4'h0, v);
    chk(tag, v, exp);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_i = 1'b0; btn = 7'h01; adr_i = 4'h0; dat_i = 32'h0; sel_i = 4'h0;
    we_i = 1'b0; stb_i = 1'b0;
    cycles(3);
    chk("rst_ack", {31'h0, ack_o}, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_irq", {31'h0, irq_o}, 32'h0);
    rst_i = 1'b1;
    cycles(1);

    // Reset values
    rd("rst_level", 4'h0, 32'h01);
    rd("rst_pend",  4'h4, 32'h0);
    rd("rst_en",    4'h8, 32'h0);
    rd("rst_edge",  4'hC, 32'h0);
    chk("rst_irq_run", {31'h0, irq_o}, 32'h0);

    // Rising edge on btn[6]: irq exactly 8 cycles after the pin change
    wr(4'hC, 32'h40, 4'hF);
    wr(4'h8, 32'h40, 4'hF);
    btn = 7'h41;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 7) chk("rise_irq_c7", {31'h0, irq_o}, 32'h0);
      if (k == 8) chk("rise_irq_c8", {31'h0, irq_o}, 32'h1);
    end
    rd("rise_pend",  4'h4, 32'h40);
    rd("rise_level", 4'h0, 32'h41);
    wr(4'h4, 32'h40, 4'hF);
    chk("w1c_irq", {31'h0, irq_o}, 32'h0);
    rd("w1c_pend", 4'h4, 32'h0);

    // Glitch rejection then a real edge on btn[3]
    wr(4'hC, 32'h7F7F, 4'hF);
    btn = 7'h49;
    cycles(3);
    btn = 7'h41;
    cycles(8);
    rd("glitch_level", 4'h0, 32'h41);
    rd("glitch_pend",  4'h4, 32'h0);
    btn = 7'h49;
    cycles(8);
    rd("hold_level", 4'h0, 32'h49);
    rd("hold_pend",  4'h4, 32'h08);
    chk("hold_irq_masked", {31'h0, irq_o}, 32'h0);
    wr(4'h4, 32'h7F, 4'hF);
    rd("hold_pend_clr", 4'h4, 32'h0);

    // Falling edge on btn[0] while masked, then unmask
    wr(4'hC, 32'h0100, 4'hF);
    wr(4'h8, 32'h0, 4'hF);
    btn = 7'h48;
    cycles(10);
    rd("fall_pend",  4'h4, 32'h01);
    rd("fall_level", 4'h0, 32'h48);
    chk("fall_irq_masked", {31'h0, irq_o}, 32'h0);
    wr(4'h8, 32'h01, 4'hF);
    chk("fall_irq_unmask", {31'h0, irq_o}, 32'h1);

    // W1C of bit2 commits on the edge where its rise event sets pending
    wr(4'h4, 32'h7F, 4'hF);
    wr(4'hC, 32'h0004, 4'hF);
    btn = 7'h4C;
    cycles(6);
    wr(4'h4, 32'h04, 4'hF);
    rd("collide_pend", 4'h4, 32'h04);

    // Byte lanes and ignored LEVEL writes
    wr(4'hC, 32'hFFFF, 4'h1);
    rd("lane_edge", 4'hC, 32'h007F);
    wr(4'h8, 32'h7F, 4'h2);
    rd("lane_en", 4'h8, 32'h01);
    wr(4'h0, 32'h7F, 4'hF);
    rd("level_ro", 4'h0, 32'h4C);
    wr(4'h8, 32'h04, 4'hF);
    chk("pre_rst_irq", {31'h0, irq_o}, 32'h1);
    rd("pre_rst_edge", 4'hC, 32'h007F);

    // Asynchronous reset in the middle of a read
    adr_i = 4'h4; we_i = 1'b0; stb_i = 1'b1;
    #2 rst_i = 1'b0;
    #1;
    chk("arst_ack", {31'h0, ack_o}, 32'h0);
    chk("arst_dat", dat_o, 32'h0);
    chk("arst_irq", {31'h0, irq_o}, 32'h0);
    @(posedge clk); #1;
    chk("arst_no_ack", {31'h0, ack_o}, 32'h0);
    stb_i = 1'b0;
    rst_i = 1'b1;
    rd("arst_level", 4'h0, 32'h01);
    rd("arst_pend",  4'h4, 32'h0);
    rd("arst_en",    4'h8, 32'h0);
    rd("arst_edge",  4'hC, 32'h0);
    chk("arst_irq_run", {31'h0, irq_o}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
